// File: rtl/gen_dff_pipe.sv
// DEPTH-stage register pipeline with per-stage valid bits, global stall (en),
// synchronous flush and a registered occupancy count.
module gen_dff_pipe #(
  parameter int                 WIDTH     = 10,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              d,
  input  logic                          d_valid,
  output logic [WIDTH-1:0]              q,
  output logic                          q_valid,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // Data shifts on en regardless of flush; q is don't-care once valids clear.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (en) begin
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    occ_d   = occ_q;
    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
    end else if (en) begin
      valid_d[0] = d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
      end
      // Word entering minus word falling off the end; stays within 0..DEPTH.
      occ_d = occ_q + OCC_W'(d_valid) - OCC_W'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign q         = stage_q[DEPTH-1];
  assign q_valid   = valid_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule
